// File: rtl/battle_pkg.sv
`default_nettype none
// ============================================================================
// Module      : battle_pkg
// Description : Shared definitions for the battle sequencer: team geometry,
//               the "no pet alive" index, the FSM state type and the stat
//               helper functions used by the sequencer datapath.
// Revision    : 1.0 - initial release
// ============================================================================
package battle_pkg;

  localparam int TEAM_SIZE = 3;
  localparam int STAT_W    = 4;
  localparam int TEAM_W    = TEAM_SIZE * STAT_W;

  localparam logic [1:0] NONE_IDX = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FIGHT = 2'd1,
    DONE  = 2'd2
  } state_e;

  // Health minus damage, clamped at zero so a pet never wraps back to life.
  function automatic logic [STAT_W-1:0] sat_sub(input logic [STAT_W-1:0] a,
                                                input logic [STAT_W-1:0] b);
    return (a > b) ? (a - b) : '0;
  endfunction

  // Extract one slot from a packed team vector. An out-of-range index
  // (NONE_IDX) yields 0; callers only use it when the index is valid.
  function automatic logic [STAT_W-1:0] get_slot(input logic [TEAM_W-1:0] v,
                                                 input logic [1:0]        idx);
    logic [STAT_W-1:0] r;
    r = '0;
    for (int i = 0; i < TEAM_SIZE; i++) begin
      if (idx == 2'(i)) r = v[i*STAT_W +: STAT_W];
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/front_select.sv
`default_nettype none
// ============================================================================
// Module      : front_select
// Description : Priority encoder that returns the lowest-index slot whose
//               health is nonzero, or NONE_IDX when the whole team is down.
// Ports       : hp_i  - packed team health, slot i at [4i+3:4i]
//               idx_o - front pet index, NONE_IDX if none alive
// Revision    : 1.0 - initial release
// ============================================================================
module front_select
  import battle_pkg::*;
(
  input  logic [TEAM_W-1:0] hp_i,
  output logic [1:0]        idx_o
);

  // Scan from the highest slot down so the lowest alive slot is the last
  // assignment and therefore wins.
  always_comb begin
    idx_o = NONE_IDX;
    for (int i = TEAM_SIZE - 1; i >= 0; i--) begin
      if (hp_i[i*STAT_W +: STAT_W] != '0) idx_o = 2'(i);
    end
  end

endmodule
`default_nettype wire

// File: rtl/battle_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : battle_sequencer
// Description : Auto-battle engine. Captures both teams on start_battle, then
//               on each tick the two front pets hit each other at once.
//               The battle ends when either team has no pet left standing.
// Ports       : clk, reset          - clock, synchronous active-high reset
//               start_battle        - begin a battle (honoured in IDLE only)
//               tick                - strike pacing enable
//               p_atk_in/p_hp_in    - player stats, 3 x 4-bit packed
//               o_atk_in/o_hp_in    - opponent stats, 3 x 4-bit packed
//               busy                - battle in progress (FIGHT or DONE)
//               strike              - pulse in the cycle updated hp appears
//               battle_done         - one-cycle end-of-battle pulse
//               battle_win          - result, held until next battle end
//               p_front/o_front     - front pet index, 3 = none alive
//               p_hp/o_hp           - live health registers
// Revision    : 1.0 - initial release
// ============================================================================
module battle_sequencer
  import battle_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start_battle,
  input  logic              tick,
  input  logic [TEAM_W-1:0] p_atk_in,
  input  logic [TEAM_W-1:0] p_hp_in,
  input  logic [TEAM_W-1:0] o_atk_in,
  input  logic [TEAM_W-1:0] o_hp_in,
  output logic              busy,
  output logic              strike,
  output logic              battle_done,
  output logic              battle_win,
  output logic [1:0]        p_front,
  output logic [1:0]        o_front,
  output logic [TEAM_W-1:0] p_hp,
  output logic [TEAM_W-1:0] o_hp
);

  state_e            state_q, state_d;
  logic [TEAM_W-1:0] p_atk_q, p_atk_d;
  logic [TEAM_W-1:0] p_hp_q,  p_hp_d;
  logic [TEAM_W-1:0] o_atk_q, o_atk_d;
  logic [TEAM_W-1:0] o_hp_q,  o_hp_d;
  logic              strike_q, strike_d;
  logic              win_q,    win_d;

  logic              p_alive;
  logic              o_alive;
  logic [STAT_W-1:0] p_front_atk;
  logic [STAT_W-1:0] o_front_atk;

  // Front selection works on the stored health, so a pet that faints on
  // one exchange is skipped automatically on the very next evaluation.
  front_select u_p_front (
    .hp_i  (p_hp_q),
    .idx_o (p_front)
  );

  front_select u_o_front (
    .hp_i  (o_hp_q),
    .idx_o (o_front)
  );

  assign p_alive     = (p_front != NONE_IDX);
  assign o_alive     = (o_front != NONE_IDX);
  assign p_front_atk = get_slot(p_atk_q, p_front);
  assign o_front_atk = get_slot(o_atk_q, o_front);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      p_atk_q  <= '0;
      p_hp_q   <= '0;
      o_atk_q  <= '0;
      o_hp_q   <= '0;
      strike_q <= 1'b0;
      win_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      p_atk_q  <= p_atk_d;
      p_hp_q   <= p_hp_d;
      o_atk_q  <= o_atk_d;
      o_hp_q   <= o_hp_d;
      strike_q <= strike_d;
      win_q    <= win_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    p_atk_d  = p_atk_q;
    p_hp_d   = p_hp_q;
    o_atk_d  = o_atk_q;
    o_hp_d   = o_hp_q;
    strike_d = 1'b0;
    win_d    = win_q;

    unique case (state_q)
      IDLE: begin
        if (start_battle) begin
          p_atk_d = p_atk_in;
          p_hp_d  = p_hp_in;
          o_atk_d = o_atk_in;
          o_hp_d  = o_hp_in;
          state_d = FIGHT;
        end
      end

      FIGHT: begin
        // A wiped team ends the battle even if a tick arrives this cycle.
        if (!p_alive || !o_alive) begin
          win_d   = p_alive && !o_alive;
          state_d = DONE;
        end else if (tick) begin
          // Both hits use pre-exchange values: a simultaneous trade.
          for (int i = 0; i < TEAM_SIZE; i++) begin
            if (p_front == 2'(i)) begin
              p_hp_d[i*STAT_W +: STAT_W] = sat_sub(p_hp_q[i*STAT_W +: STAT_W], o_front_atk);
            end
            if (o_front == 2'(i)) begin
              o_hp_d[i*STAT_W +: STAT_W] = sat_sub(o_hp_q[i*STAT_W +: STAT_W], p_front_atk);
            end
          end
          strike_d = 1'b1;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // strike is registered so it lines up with the updated hp it announces;
  // battle_done decodes DONE, landing two cycles after the final tick.
  assign busy        = (state_q != IDLE);
  assign strike      = strike_q;
  assign battle_done = (state_q == DONE);
  assign battle_win  = win_q;
  assign p_hp        = p_hp_q;
  assign o_hp        = o_hp_q;

endmodule
`default_nettype wire

// File: doc/battle_sequencer.md
BATTLE_SEQUENCER -- requirements
Module: battle_sequencer

Interface
REQ-001 clk  input  1  system clock; reset  input  1  reset, synchronous, active-high.
REQ-002 start_battle  input  1  one-cycle pulse from the game controller on entry to the battle screen.
REQ-003 tick  input  1  one-cycle strike-pacing enable from the slow timer.
REQ-004 p_atk_in  input  12  player attack, slot i at bits [4i+3:4i].
REQ-005 p_hp_in  input  12  player health, same packing; 0 means empty slot.
REQ-006 o_atk_in, o_hp_in  input  12 each  opponent attack and health, same packing.
REQ-007 busy  output  1  high while a battle is in progress.
REQ-008 strike  output  1  one-cycle pulse on each applied exchange.
REQ-009 battle_done  output  1  one-cycle pulse at battle end.
REQ-010 battle_win  output  1  result, valid whenever battle_done=1.
REQ-011 p_front, o_front  output  2 each  index of the current front pet; 3 means none alive.
REQ-012 p_hp, o_hp  output  12 each  live health registers, same packing, used for drawing.

Function
REQ-013 FSM states: IDLE, FIGHT, DONE.
REQ-014 IDLE: on start_battle=1, capture all four stat inputs into internal registers that cycle; go to FIGHT next cycle.
REQ-015 start_battle outside IDLE shall be ignored.
REQ-016 A slot is alive iff its health register is nonzero; the front pet is the lowest-index alive slot.
REQ-017 FIGHT: if either team has no alive slot, go to DONE; the team check takes priority over tick.
REQ-018 FIGHT with both teams alive and tick=1: apply both hits simultaneously in one cycle and assert strike that cycle.
  - player front hp := hp - opponent front atk, saturating at 0.
  - opponent front hp := hp - player front atk, saturating at 0.
REQ-019 FIGHT with tick=0: hold all registers.
REQ-020 Front advance is implicit: a fainted slot (hp=0) is skipped on the next evaluation, with no extra cycle.
REQ-021 Attack 0 is legal and gives no damage. A battle where both attacks are 0 never ends; the controller accepts this.
REQ-022 DONE: assert battle_done for exactly one cycle, then return to IDLE.
REQ-023 battle_win is set when the opponent has no alive slot and the player has at least one. A mutual wipe, or both teams empty, is a loss.
REQ-024 battle_win is held until the next DONE or reset.
REQ-025 Latency:
  - Final strike on cycle N gives battle_done on cycle N+2.
  - Team already empty at load: start on cycle S gives battle_done on cycle S+2.
REQ-026 busy=1 in FIGHT and DONE; busy=0 in IDLE.
REQ-027 The hp registers keep their final values in IDLE, for the results screen, until the next start_battle.
REQ-028 All outputs come from registers or from decoding registered state. There is no combinational path from input to output except through the front-select logic on stored hp.

Reset
REQ-029 Reset returns the FSM to IDLE from any state, including mid-FIGHT and DONE.
REQ-030 Reset clears all stat registers to 0 and drives strike=0, battle_done=0, battle_win=0, busy=0.
REQ-031 After reset, p_front and o_front read 3.
REQ-032 A tick or start_battle in the same cycle as reset shall be ignored.

Structure
REQ-033 Shared package battle_pkg holds TEAM_SIZE=3, STAT_W=4, NONE_IDX=2'd3 and the FSM state enum typedef.
REQ-034 Sub-module front_select: a priority encoder from 3 hp fields to the first-alive index, returning NONE_IDX if none. Instantiate it once per team.
REQ-035 The saturating subtract is a function in battle_pkg.

Verification
REQ-036 Basic win:
  - Stimulus: player atk {3,2,1}, hp {5,4,3}; opponent atk {1,1,1}, hp {2,2,2}; tick every 4 cycles.
  - Response: three strikes, one per tick; final o_hp=0; battle_done=1 with battle_win=1; p_hp slot0=2.
REQ-037 Mutual wipe:
  - Stimulus: single slot each side, atk 5, hp 5.
  - Response: one strike; both hp=0; battle_done two cycles later; battle_win=0.
REQ-038 Empty team:
  - Stimulus: p_hp_in=0, any opponent.
  - Response: no strike; battle_done at S+2; battle_win=0.
REQ-039 Skip empty slot:
  - Stimulus: player hp {0,6,0}.
  - Response: p_front=1 throughout; hits land on slot1 only.
REQ-040 Reset mid-fight:
  - Stimulus: assert reset during FIGHT after one strike.
  - Response: next cycle IDLE, busy=0, hp registers 0, no battle_done; a new start_battle runs a clean battle.
REQ-041 Ignored events:
  - Stimulus: start_battle during FIGHT; tick while in IDLE.
  - Response: no reload; no strike.
